// File: rtl/int_muldiv_unit.sv
// int_muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
// Shift-add multiplier and restoring divider, one bit per cycle, working on
// operand magnitudes with a final sign fix-up. Division by zero and signed
// overflow bypass the iteration. W forms operate on 32 bits and return a
// sign-extended result.
//
// Handshake (both ports): a transfer happens on a rising edge where valid and
// ready are both high. Once resp_valid_o is raised it stays high with stable
// data and tag until resp_ready_i takes it. req_ready_o depends only on state,
// reset and flush, never on req_valid_i.
module int_muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_funct3_i,
    input  logic             req_word_i,
    input  logic [XLEN-1:0]  req_a_i,
    input  logic [XLEN-1:0]  req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic [1:0]       dbg_state_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_REM    = 3'b110;

    // Most-negative dividend for full-width and for sign-extended W operands.
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = ~(XLEN'(32'h7FFF_FFFF));

    localparam logic [CNT_W-1:0] LAST_X = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] LAST_W = CNT_W'(31);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Extend the low 32 bits of x to XLEN, with sign when sgn is set.
    function automatic logic [XLEN-1:0] f_ext32(input logic [XLEN-1:0] x, input logic sgn);
        logic [XLEN-1:0] r;
        r = x;
        for (int i = 32; i < XLEN; i++) begin
            r[i] = sgn & x[31];
        end
        return r;
    endfunction

    // Request decode
    logic            w_accept;
    logic            w_word;
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_min;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_raw;
    logic [XLEN-1:0] w_fast_res;

    // Latched operation and datapath registers
    logic [2:0]       r_f3;
    logic             r_word;
    logic [TAG_W-1:0] r_tag;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]  r_mplier;
    logic [XLEN-1:0]  r_dquo;
    logic [XLEN-1:0]  r_drem;
    logic [XLEN-1:0]  r_dvsr;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_data;

    // Iteration and result formatting
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [XLEN:0]     w_div_shift;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_diff;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_prod_hi_w;
    logic [XLEN-1:0]   w_mul_raw;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_calc_raw;
    logic [XLEN-1:0]   w_calc_res;
    logic              w_last;

    assign req_ready_o = (r_state == S_IDLE) && !rst_i && !flush_i;
    assign w_accept    = req_valid_i && req_ready_o;

    assign w_word     = (XLEN == 64) && req_word_i;
    assign w_is_div   = req_funct3_i[2];
    assign w_a_signed = (req_funct3_i == F3_MUL) || (req_funct3_i == F3_MULH) ||
                        (req_funct3_i == F3_MULHSU) || (req_funct3_i == F3_DIV) ||
                        (req_funct3_i == F3_REM);
    assign w_b_signed = (req_funct3_i == F3_MUL) || (req_funct3_i == F3_MULH) ||
                        (req_funct3_i == F3_DIV) || (req_funct3_i == F3_REM);

    assign w_a_ext = w_word ? f_ext32(req_a_i, w_a_signed) : req_a_i;
    assign w_b_ext = w_word ? f_ext32(req_b_i, w_b_signed) : req_b_i;
    assign w_a_neg = w_a_signed && w_a_ext[XLEN-1];
    assign w_b_neg = w_b_signed && w_b_ext[XLEN-1];
    assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

    assign w_min      = w_word ? MIN_W : MIN_X;
    assign w_div_zero = w_is_div && (w_b_ext == '0);
    assign w_div_ovf  = w_is_div && !req_funct3_i[0] && (w_a_ext == w_min) && (w_b_ext == '1);
    assign w_fast     = w_div_zero || w_div_ovf;

    // Results of the special divide cases that need no iteration.
    always_comb begin
        w_fast_raw = '0;
        if (w_div_zero) begin
            w_fast_raw = req_funct3_i[1] ? w_a_ext : '1;
        end else if (w_div_ovf) begin
            w_fast_raw = req_funct3_i[1] ? '0 : w_a_ext;
        end
    end

    assign w_fast_res = w_word ? f_ext32(w_fast_raw, 1'b1) : w_fast_raw;

    // One multiplier bit and one restoring-divide step per CALC cycle.
    assign w_acc_nxt   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_div_shift = {r_drem, r_dquo[XLEN-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_dvsr});
    assign w_div_diff  = w_div_shift[XLEN-1:0] - r_dvsr;
    assign w_rem_nxt   = w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
    assign w_quo_nxt   = {r_dquo[XLEN-2:0], w_div_ge};

    // Sign fix-up and selection, evaluated on the values of the final step.
    assign w_prod      = r_neg_res ? -w_acc_nxt : w_acc_nxt;
    assign w_prod_hi_w = XLEN'(w_prod >> 32);

    // Pick low or high half of the product depending on the opcode.
    always_comb begin
        w_mul_raw = w_prod[XLEN-1:0];
        if (r_f3 != F3_MUL) begin
            w_mul_raw = r_word ? w_prod_hi_w : w_prod[2*XLEN-1:XLEN];
        end
    end

    assign w_quo_s    = r_neg_res ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_s    = r_neg_rem ? -w_rem_nxt : w_rem_nxt;
    assign w_calc_raw = r_f3[2] ? (r_f3[1] ? w_rem_s : w_quo_s) : w_mul_raw;
    assign w_calc_res = r_word ? f_ext32(w_calc_raw, 1'b1) : w_calc_raw;
    assign w_last     = (r_cnt == (r_word ? LAST_W : LAST_X));

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Datapath: latch operands on acceptance, iterate in CALC, capture result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_f3      <= '0;
            r_word    <= 1'b0;
            r_tag     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_dquo    <= '0;
            r_drem    <= '0;
            r_dvsr    <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
        end else if (w_accept) begin
            r_f3      <= req_funct3_i;
            r_word    <= w_word;
            r_tag     <= req_tag_i;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_acc     <= '0;
            r_mcand   <= {{XLEN{1'b0}}, w_a_mag};
            r_mplier  <= w_b_mag;
            // W dividends start at the top so the MSB-first shift sees bit 31 first.
            r_dquo    <= w_word ? (w_a_mag << 32) : w_a_mag;
            r_drem    <= '0;
            r_dvsr    <= w_b_mag;
            r_cnt     <= '0;
            if (w_fast) begin
                r_data <= w_fast_res;
            end
        end else if ((r_state == S_CALC) && !flush_i) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_dquo   <= w_quo_nxt;
            r_drem   <= w_rem_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_data <= w_calc_res;
            end
        end
    end

    assign resp_valid_o = (r_state == S_DONE);
    assign resp_data_o  = r_data;
    assign resp_tag_o   = r_tag;
    assign dbg_state_o  = r_state;

endmodule
